// File: rtl/revaluate_datapath.sv
// -----------------------------------------------------------------------------
// revaluate_datapath
//
// Streams 25-bit state slices from a synchronous-read source memory through a
// row-wise nonlinear revaluation and writes them to a destination memory.
// A slice is a 5x5 bit plane with bit index 5*y+x (row y, column x). Every row
// is transformed independently:
//   out[x] = b[x] ^ (~b[(x+1)%5] & b[(x+2)%5])
//
// A slice counter addresses the source memory directly. The source returns its
// data one cycle later, so the write address and strobe pass through a single
// register stage to line up with rd_data.
//
// Ports
//   clk            in   clock, all state changes on the rising edge
//   rst            in   synchronous active-high reset
//   dataset_reset  in   clear slice counter, drop the write in flight
//   count          in   advance slice counter (wraps after SLICES-1)
//   write          in   process and write the slice currently addressed
//   rd_addr        out  source slice address (the counter itself)
//   rd_data        in   source slice, valid one cycle after rd_addr
//   wr_en          out  destination write strobe
//   wr_addr        out  destination slice address
//   wr_data        out  revaluated slice, zero when wr_en is low
//   datapath_done  out  last slice addressed while counting
//
// Strobe semantics: the controller inputs are single-cycle level requests with
// no backpressure; wr_en is a one-cycle qualifier for wr_addr/wr_data and the
// destination must accept every cycle in which it is high.
// -----------------------------------------------------------------------------
module revaluate_datapath #(
  parameter int SLICES = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dataset_reset,
  input  logic              count,
  input  logic              write,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [24:0]       rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [24:0]       wr_data,
  output logic              datapath_done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SLICES - 1);

  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] pipe_addr;
  logic              pipe_vld;

  // Row-wise revaluation of one 25-bit slice.
  function automatic logic [24:0] revaluate(input logic [24:0] b);
    logic [24:0] r;
    r = '0;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        r[5*y + x] = b[5*y + x] ^ (~b[5*y + ((x + 1) % 5)] & b[5*y + ((x + 2) % 5)]);
      end
    end
    return r;
  endfunction

  // Slice counter: rst, then dataset_reset, then count, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (dataset_reset) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // Alignment stage: the address seen this cycle is the one whose data the
  // source memory returns next cycle. dataset_reset kills the write in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld  <= 1'b0;
      pipe_addr <= '0;
    end else begin
      pipe_vld  <= write & ~dataset_reset;
      pipe_addr <= cnt;
    end
  end

  assign rd_addr       = cnt;
  assign wr_en         = pipe_vld;
  assign wr_addr       = pipe_addr;
  assign wr_data       = pipe_vld ? revaluate(rd_data) : '0;
  assign datapath_done = count & ~dataset_reset & (cnt == LAST);

endmodule
